// File: rtl/store_pkg.sv
// Shared store-path definitions: funct3 encodings and the store-buffer entry layout.
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// Store source select, lane replication and byte-enable generation; purely combinational.
// Flags misaligned halfword/word stores, FP source with a non-word size, and unknown funct3.
module store_align
  import store_pkg::*;
(
  input  logic        fp_sel_i,
  input  logic [31:0] int_data_i,
  input  logic [31:0] fp_data_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        err_o
);

  logic [31:0] data;

  always_comb begin
    data    = fp_sel_i ? fp_data_i : int_data_i;
    wdata_o = '0;
    be_o    = '0;
    err_o   = 1'b0;
    case (funct3_i)
      F3_SB: begin
        wdata_o = {4{data[7:0]}};
        be_o    = 4'b0001 << off_i;
        err_o   = fp_sel_i;
      end
      F3_SH: begin
        wdata_o = {2{data[15:0]}};
        be_o    = 4'b0011 << off_i;
        err_o   = fp_sel_i | off_i[0];
      end
      F3_SW: begin
        wdata_o = data;
        be_o    = 4'b1111;
        err_o   = (off_i != 2'b00);
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// In-order store buffer draining to data memory over req/ack; push to mem_req is one cycle.
// st_ready depends only on the registered count, so a full buffer refuses pushes even on ack.
module store_unit
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic        st_fp_sel,
  input  logic [31:0] st_int_data,
  input  logic [31:0] st_fp_data,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_funct3,
  output logic        st_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  sb_entry_t     buf_q [DEPTH];
  sb_entry_t     out_q, out_d, new_entry;
  logic          st_err_q;

  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic        al_err;
  logic        push, pop, load_out;
  logic        unused_ld_off;

  store_align u_align (
    .fp_sel_i   (st_fp_sel),
    .int_data_i (st_int_data),
    .fp_data_i  (st_fp_data),
    .off_i      (st_addr[1:0]),
    .funct3_i   (st_funct3),
    .wdata_o    (al_wdata),
    .be_o       (al_be),
    .err_o      (al_err)
  );

  assign st_ready  = (count_q < CW'(DEPTH));
  assign sb_empty  = (count_q == '0);
  assign mem_req   = (state_q == S_BUSY);
  assign st_err    = st_err_q;
  assign mem_addr  = {out_q.addr, 2'b00};
  assign mem_wdata = out_q.wdata;
  assign mem_be    = out_q.be;

  assign push      = st_valid && st_ready && !al_err;
  assign pop       = mem_req && mem_ack;
  assign new_entry = '{addr: st_addr[31:2], wdata: al_wdata, be: al_be};

  always_comb begin
    count_d  = count_q + CW'(push) - CW'(pop);
    head_d   = head_q + PW'(pop);
    tail_d   = tail_q + PW'(push);
    state_d  = (count_d != '0) ? S_BUSY : S_IDLE;
    // The pushed entry becomes the head when nothing else remains ahead of it.
    out_d    = (push && (tail_q == head_d)) ? new_entry : buf_q[head_d];
    load_out = ((push && (count_q == '0)) || pop) && (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      out_q    <= '0;
      st_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      st_err_q <= st_valid && al_err;
      if (load_out) out_q <= out_d;
      if (push) buf_q[tail_q] <= new_entry;
    end
  end

  // Slots are valid by distance from head, so an entry being popped still aliases this cycle.
  always_comb begin
    logic [PW-1:0] rel;
    rel         = '0;
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PW'(i) - head_q;
      if (({1'b0, rel} < count_q) && (buf_q[i].addr == ld_addr[31:2])) ld_conflict = 1'b1;
    end
  end

  assign unused_ld_off = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios plus random traffic against a queue model.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, st_ready, st_fp_sel, st_err;
  logic [31:0] st_int_data, st_fp_data, st_addr;
  logic [2:0]  st_funct3;
  logic        mem_req, mem_ack, ld_conflict, sb_empty;
  logic [31:0] mem_addr, mem_wdata, ld_addr;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  store_unit #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_fp_sel   (st_fp_sel),
    .st_int_data (st_int_data),
    .st_fp_data  (st_fp_data),
    .st_addr     (st_addr),
    .st_funct3   (st_funct3),
    .st_err      (st_err),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .ld_addr     (ld_addr),
    .ld_conflict (ld_conflict),
    .sb_empty    (sb_empty)
  );

  typedef struct {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  localparam int MDEPTH = 2;

  ent_t mq[$];
  logic err_exp;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic ref_err(input logic fp, input logic [2:0] f3, input logic [1:0] off);
    if (f3 > 3'd2) return 1'b1;
    if (fp && f3 != 3'd2) return 1'b1;
    if (f3 == 3'd1 && off[0]) return 1'b1;
    if (f3 == 3'd2 && off != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ent_t ref_ent(input logic fp, input logic [31:0] id, input logic [31:0] fd,
                                   input logic [31:0] a, input logic [2:0] f3);
    ent_t        e;
    logic [31:0] d;
    int          off;
    d       = fp ? fd : id;
    off     = int'(a % 4);
    e.waddr = a[31:2];
    if (f3 == 3'd0) begin
      e.data = 32'(d[7:0]) * 32'h0101_0101;
      e.be   = 4'(1 << off);
    end else if (f3 == 3'd1) begin
      e.data = 32'(d[15:0]) * 32'h0001_0001;
      e.be   = 4'(3 << off);
    end else begin
      e.data = d;
      e.be   = 4'hF;
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic fp, input logic [31:0] id, input logic [31:0] fd,
                       input logic [31:0] a, input logic [2:0] f3, input logic ack,
                       input logic [31:0] la);
    st_valid = v; st_fp_sel = fp; st_int_data = id; st_fp_data = fd;
    st_addr = a; st_funct3 = f3; mem_ack = ack; ld_addr = la;
  endtask

  // Check current outputs against the model, then advance the model across one rising edge.
  task automatic cycle();
    logic hit, rdy, e, popping, pushing;
    #1;
    chk("mem_req", mem_req, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("mem_addr", mem_addr, {mq[0].waddr, 2'b00});
      chk("mem_wdata", mem_wdata, mq[0].data);
      chk("mem_be", mem_be, mq[0].be);
    end
    chk("st_ready", st_ready, mq.size() < MDEPTH);
    chk("sb_empty", sb_empty, mq.size() == 0);
    chk("st_err", st_err, err_exp);
    hit = 1'b0;
    foreach (mq[i]) if (mq[i].waddr == ld_addr[31:2]) hit = 1'b1;
    chk("ld_conflict", ld_conflict, hit);
    @(posedge clk);
    rdy     = mq.size() < MDEPTH;
    e       = ref_err(st_fp_sel, st_funct3, st_addr[1:0]);
    popping = (mq.size() != 0) && mem_ack;
    pushing = st_valid && rdy && !e;
    err_exp = st_valid && e;
    if (popping) void'(mq.pop_front());
    if (pushing) mq.push_back(ref_ent(st_fp_sel, st_int_data, st_fp_data, st_addr, st_funct3));
    @(negedge clk);
  endtask

  task automatic idle(input logic ack, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, ack, 32'hFFFF_FFF0);
      cycle();
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    err_exp = 1'b0;
    rst_n   = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
    #2;
    chk("rst mem_req", mem_req, 1'b0);
    chk("rst st_ready", st_ready, 1'b1);
    chk("rst st_err", st_err, 1'b0);
    chk("rst sb_empty", sb_empty, 1'b1);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_be", mem_be, 32'h0);
    chk("rst ld_conflict", ld_conflict, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait word store
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h100, 3'd2, 1'b1, 32'h0);
    cycle();
    idle(1'b1, 2);

    // Byte and halfword lanes
    drive(1'b1, 1'b0, 32'h0000_00A5, 32'h0, 32'h203, 3'd0, 1'b1, 32'h0);
    cycle();
    drive(1'b1, 1'b0, 32'h0000_1234, 32'h0, 32'h202, 3'd1, 1'b1, 32'h0);
    cycle();
    idle(1'b1, 2);

    // Rejected stores
    drive(1'b1, 1'b0, 32'h1111_1111, 32'h0, 32'h201, 3'd1, 1'b1, 32'h0);
    cycle();
    drive(1'b1, 1'b0, 32'h2222_2222, 32'h0, 32'h102, 3'd2, 1'b1, 32'h0);
    cycle();
    drive(1'b1, 1'b1, 32'h3333_3333, 32'h4444_4444, 32'h104, 3'd0, 1'b1, 32'h0);
    cycle();
    idle(1'b1, 2);

    // Backpressure with FP source, then drain with a push on the ack edge
    drive(1'b1, 1'b1, 32'h0BAD_0BAD, 32'h3F80_0000, 32'h500, 3'd2, 1'b0, 32'h0);
    cycle();
    drive(1'b1, 1'b0, 32'hCAFE_F00D, 32'h0, 32'h504, 3'd2, 1'b0, 32'h0);
    cycle();
    drive(1'b1, 1'b0, 32'h5555_5555, 32'h0, 32'h508, 3'd2, 1'b0, 32'h0);
    cycle();
    idle(1'b0, 2);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h0);
    cycle();
    drive(1'b1, 1'b0, 32'h7777_7777, 32'h0, 32'h50C, 3'd2, 1'b1, 32'h0);
    cycle();
    drive(1'b1, 1'b0, 32'h8888_8888, 32'h0, 32'h510, 3'd2, 1'b1, 32'h0);
    cycle();
    idle(1'b1, 3);

    // Load aliasing
    drive(1'b1, 1'b0, 32'h9999_9999, 32'h0, 32'h300, 3'd2, 1'b0, 32'h302);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h302);
    cycle();
    drive(1'b1, 1'b0, 32'hAAAA_AAAA, 32'h0, 32'h304, 3'd2, 1'b0, 32'h304);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h300);
    cycle();

    // Asynchronous reset with two pending entries
    drive(1'b1, 1'b0, 32'hBBBB_BBBB, 32'h0, 32'h600, 3'd2, 1'b0, 32'h0);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
    #1;
    chk("pre-reset pending", mq.size(), 32'd2);
    chk("pre-reset mem_req", mem_req, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst mem_req", mem_req, 1'b0);
    chk("arst sb_empty", sb_empty, 1'b1);
    chk("arst st_ready", st_ready, 1'b1);
    chk("arst ld_conflict", ld_conflict, 1'b0);
    mq.delete();
    err_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1, 4);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: f3 = 3'd0;
        3, 4, 5: f3 = 3'd1;
        6, 7, 8: f3 = 3'd2;
        default: f3 = 3'($urandom_range(3, 7));
      endcase
      a = 32'h400 + 32'($urandom_range(0, 3) * 4);
      if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(0, 3));
      else if (f3 == 3'd0) a = a + 32'($urandom_range(0, 3));
      else if (f3 == 3'd1) a = a + 32'($urandom_range(0, 1) * 2);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom, $urandom, a, f3,
            $urandom_range(0, 2) != 0, 32'h400 + 32'($urandom_range(0, 19)));
      cycle();
    end
    idle(1'b1, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
